// File: rtl/kf8259_common_pkg.sv
// Shared 8259 definitions: acknowledge FSM states, level width and the
// rotate / lowest-set-bit / one-hot-to-index helpers used by the ISR and resolver logic.
package kf8259_common_pkg;

    localparam int LEVEL_W    = 3;
    localparam int NUM_LEVELS = 8;

    typedef enum logic {
        ST_IDLE        = 1'b0,
        ST_WAIT_SECOND = 1'b1
    } ack_state_t;

    function automatic logic [NUM_LEVELS-1:0] rotate_right(
        input logic [NUM_LEVELS-1:0] value,
        input logic [LEVEL_W-1:0]    amount
    );
        logic [2*NUM_LEVELS-1:0] doubled;
        doubled = {value, value} >> amount;
        return doubled[NUM_LEVELS-1:0];
    endfunction

    function automatic logic [NUM_LEVELS-1:0] rotate_left(
        input logic [NUM_LEVELS-1:0] value,
        input logic [LEVEL_W-1:0]    amount
    );
        logic [2*NUM_LEVELS-1:0] doubled;
        doubled = {value, value} << amount;
        return doubled[2*NUM_LEVELS-1:NUM_LEVELS];
    endfunction

    // Two's-complement trick isolates the least significant set bit.
    function automatic logic [NUM_LEVELS-1:0] lowest_set_bit(
        input logic [NUM_LEVELS-1:0] value
    );
        return value & (~value + 1'b1);
    endfunction

    function automatic logic [LEVEL_W-1:0] onehot_to_index(
        input logic [NUM_LEVELS-1:0] onehot
    );
        logic [LEVEL_W-1:0] index;
        index = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (onehot[i]) begin
                index = index | LEVEL_W'(i);
            end
        end
        return index;
    endfunction

endpackage

// File: rtl/kf8259_in_service_control.sv
// 8259 in-service register, INTA acknowledge sequencing, EOI handling and priority rotation.
// Optional macro KF8259_AUTO_ROTATE_EN lets automatic EOI rotate priority.
module kf8259_in_service_control
    import kf8259_common_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_LEVELS-1:0] interrupt,
    input  logic                  interrupt_acknowledge,
    input  logic                  auto_eoi_config,
    input  logic                  auto_rotate_config,
    input  logic                  eoi_valid,
    input  logic                  eoi_specific,
    input  logic                  eoi_rotate,
    input  logic [LEVEL_W-1:0]    eoi_level,
    input  logic                  set_priority_valid,
    input  logic [LEVEL_W-1:0]    set_priority_level,
    output logic [NUM_LEVELS-1:0] in_service_register,
    output logic [NUM_LEVELS-1:0] highest_level_in_service,
    output logic [LEVEL_W-1:0]    priority_rotate,
    output logic [LEVEL_W-1:0]    acknowledged_level,
    output logic                  ack_busy
);

    ack_state_t              r_state;
    ack_state_t              w_state_next;
    logic [NUM_LEVELS-1:0]   r_isr;
    logic [NUM_LEVELS-1:0]   w_isr_next;
    logic [LEVEL_W-1:0]      r_priority_rotate;
    logic [LEVEL_W-1:0]      w_rotate_next;
    logic [LEVEL_W-1:0]      r_ack_level;
    logic [LEVEL_W-1:0]      w_ack_level_next;
    logic                    r_spurious;
    logic                    w_spurious_next;

    logic [LEVEL_W-1:0]      w_scan_start;
    logic [NUM_LEVELS-1:0]   w_highest;
    logic [NUM_LEVELS-1:0]   w_isr_clear;
    logic [NUM_LEVELS-1:0]   w_isr_set;
    logic                    w_eoi_rotate;
    logic [LEVEL_W-1:0]      w_eoi_rotate_level;
    logic                    w_auto_rotate;

    // Rotate so the highest-priority level sits at bit 0, pick lowest bit, rotate back.
    assign w_scan_start = r_priority_rotate + 1'b1;
    assign w_highest    = rotate_left(lowest_set_bit(rotate_right(r_isr, w_scan_start)),
                                      w_scan_start);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_isr_clear        = '0;
        w_isr_set          = '0;
        w_ack_level_next   = r_ack_level;
        w_spurious_next    = r_spurious;
        w_rotate_next      = r_priority_rotate;
        w_eoi_rotate       = 1'b0;
        w_eoi_rotate_level = '0;
        w_auto_rotate      = 1'b0;

        if (eoi_valid) begin
            if (eoi_specific) begin
                w_isr_clear        = w_isr_clear | (8'b1 << eoi_level);
                w_eoi_rotate       = eoi_rotate;
                w_eoi_rotate_level = eoi_level;
            end else if (r_isr != '0) begin
                w_isr_clear        = w_isr_clear | w_highest;
                w_eoi_rotate       = eoi_rotate;
                w_eoi_rotate_level = onehot_to_index(w_highest);
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (interrupt_acknowledge) begin
                    w_isr_set        = interrupt;
                    w_spurious_next  = (interrupt == '0);
                    w_ack_level_next = (interrupt == '0) ? 3'd7 : onehot_to_index(interrupt);
                    w_state_next     = ST_WAIT_SECOND;
                end
            end
            ST_WAIT_SECOND: begin
                if (interrupt_acknowledge) begin
                    w_state_next = ST_IDLE;
                    if (auto_eoi_config && !r_spurious) begin
                        w_isr_clear = w_isr_clear | (8'b1 << r_ack_level);
`ifdef KF8259_AUTO_ROTATE_EN
                        w_auto_rotate = auto_rotate_config;
`endif
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // An explicit priority write beats an OCW2 rotate, which beats an automatic rotate.
        if (set_priority_valid) begin
            w_rotate_next = set_priority_level;
        end else if (w_eoi_rotate) begin
            w_rotate_next = w_eoi_rotate_level;
        end else if (w_auto_rotate) begin
            w_rotate_next = r_ack_level;
        end

        w_isr_next = (r_isr & ~w_isr_clear) | w_isr_set;
    end

`ifndef KF8259_AUTO_ROTATE_EN
    logic w_unused_auto_rotate;
    assign w_unused_auto_rotate = auto_rotate_config;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_isr             <= '0;
            r_priority_rotate <= 3'b111;
            r_ack_level       <= '0;
            r_spurious        <= 1'b0;
        end else begin
            r_isr             <= w_isr_next;
            r_priority_rotate <= w_rotate_next;
            r_ack_level       <= w_ack_level_next;
            r_spurious        <= w_spurious_next;
        end
    end

    assign in_service_register      = r_isr;
    assign highest_level_in_service = w_highest;
    assign priority_rotate          = r_priority_rotate;
    assign acknowledged_level       = r_ack_level;
    assign ack_busy                 = (r_state == ST_WAIT_SECOND);

endmodule

// File: tb/tb_kf8259_in_service_control.sv
// Scoreboard bench for kf8259_in_service_control: a driver pushes model predictions,
// a monitor pops and compares them one cycle later. Honours KF8259_AUTO_ROTATE_EN.
module tb_kf8259_in_service_control;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] interrupt;
    logic       interrupt_acknowledge;
    logic       auto_eoi_config;
    logic       auto_rotate_config;
    logic       eoi_valid;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic [2:0] eoi_level;
    logic       set_priority_valid;
    logic [2:0] set_priority_level;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic [2:0] acknowledged_level;
    logic       ack_busy;

    kf8259_in_service_control dut (
        .clock                    (clock),
        .reset                    (reset),
        .interrupt                (interrupt),
        .interrupt_acknowledge    (interrupt_acknowledge),
        .auto_eoi_config          (auto_eoi_config),
        .auto_rotate_config       (auto_rotate_config),
        .eoi_valid                (eoi_valid),
        .eoi_specific             (eoi_specific),
        .eoi_rotate               (eoi_rotate),
        .eoi_level                (eoi_level),
        .set_priority_valid       (set_priority_valid),
        .set_priority_level       (set_priority_level),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .priority_rotate          (priority_rotate),
        .acknowledged_level       (acknowledged_level),
        .ack_busy                 (ack_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         id;
        logic [7:0] isr;
        logic [7:0] highest;
        logic [2:0] rot;
        logic [2:0] ack;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_failures = 0;
    int   n_txn      = 0;
    bit   driver_done = 1'b0;

    // Reference model state: ISR as an array of flags, rotation and levels as plain ints.
    bit m_isr[8];
    int m_rot;
    int m_ack;
    bit m_busy;
    bit m_spur;

    function automatic int model_highest_level();
        for (int k = 1; k <= 8; k++) begin
            if (m_isr[(m_rot + k) % 8]) return (m_rot + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_isr_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_isr[i];
        return v;
    endfunction

    task automatic model_step();
        bit clr[8];
        bit setb[8];
        int h;
        int eoi_rot;
        int auto_rot;
        eoi_rot  = -1;
        auto_rot = -1;
        for (int i = 0; i < 8; i++) begin
            clr[i]  = 1'b0;
            setb[i] = 1'b0;
        end
        if (reset) begin
            for (int i = 0; i < 8; i++) m_isr[i] = 1'b0;
            m_rot  = 7;
            m_ack  = 0;
            m_busy = 1'b0;
            m_spur = 1'b0;
            return;
        end
        h = model_highest_level();
        if (eoi_valid) begin
            if (eoi_specific) begin
                clr[int'(eoi_level)] = 1'b1;
                if (eoi_rotate) eoi_rot = int'(eoi_level);
            end else if (h >= 0) begin
                clr[h] = 1'b1;
                if (eoi_rotate) eoi_rot = h;
            end
        end
        if (interrupt_acknowledge) begin
            if (!m_busy) begin
                m_busy = 1'b1;
                m_spur = (interrupt == 8'h00);
                m_ack  = 7;
                for (int i = 0; i < 8; i++) begin
                    if (interrupt[i]) begin
                        setb[i] = 1'b1;
                        m_ack   = i;
                    end
                end
            end else begin
                m_busy = 1'b0;
                if (auto_eoi_config && !m_spur) begin
                    clr[m_ack] = 1'b1;
`ifdef KF8259_AUTO_ROTATE_EN
                    if (auto_rotate_config) auto_rot = m_ack;
`endif
                end
            end
        end
        if (set_priority_valid) m_rot = int'(set_priority_level);
        else if (eoi_rot >= 0)  m_rot = eoi_rot;
        else if (auto_rot >= 0) m_rot = auto_rot;
        for (int i = 0; i < 8; i++) m_isr[i] = (m_isr[i] && !clr[i]) || setb[i];
    endtask

    task automatic drive_defaults();
        reset                 = 1'b0;
        interrupt             = 8'h00;
        interrupt_acknowledge = 1'b0;
        auto_eoi_config       = 1'b0;
        auto_rotate_config    = 1'b0;
        eoi_valid             = 1'b0;
        eoi_specific          = 1'b0;
        eoi_rotate            = 1'b0;
        eoi_level             = 3'd0;
        set_priority_valid    = 1'b0;
        set_priority_level    = 3'd0;
    endtask

    // Inputs are already set (after a negedge); predict the next edge and enqueue it.
    task automatic commit_cycle();
        exp_t e;
        int   h;
        model_step();
        h         = model_highest_level();
        e.id      = n_txn;
        e.isr     = model_isr_vec();
        e.highest = (h >= 0) ? (8'h01 << h) : 8'h00;
        e.rot     = 3'(m_rot);
        e.ack     = 3'(m_ack);
        e.busy    = m_busy;
        exp_q.push_back(e);
        n_txn++;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        drive_defaults();
        commit_cycle();
    endtask

    task automatic reset_cycle();
        @(negedge clock);
        drive_defaults();
        reset = 1'b1;
        commit_cycle();
    endtask

    task automatic inta(input logic [7:0] req, input logic aeoi, input logic arot);
        @(negedge clock);
        drive_defaults();
        interrupt             = req;
        interrupt_acknowledge = 1'b1;
        auto_eoi_config       = aeoi;
        auto_rotate_config    = arot;
        commit_cycle();
    endtask

    task automatic ack_pair(input logic [7:0] req, input logic aeoi, input logic arot);
        inta(req, aeoi, arot);
        idle_cycle();
        inta(req, aeoi, arot);
    endtask

    task automatic eoi(input logic spec, input logic rot, input logic [2:0] lvl);
        @(negedge clock);
        drive_defaults();
        eoi_valid    = 1'b1;
        eoi_specific = spec;
        eoi_rotate   = rot;
        eoi_level    = lvl;
        commit_cycle();
    endtask

    task automatic set_priority(input logic [2:0] lvl);
        @(negedge clock);
        drive_defaults();
        set_priority_valid = 1'b1;
        set_priority_level = lvl;
        commit_cycle();
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req, input int id);
        n_checks++;
        if (act !== req) begin
            n_failures++;
            $display("FAIL txn %0d %s: got %h expected %h", id, name, act, req);
        end
    endtask

    // Monitor: every result appears one edge after its stimulus was committed.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("isr",     in_service_register,       e.isr,           e.id);
                check("highest", highest_level_in_service,  e.highest,       e.id);
                check("rotate",  {5'd0, priority_rotate},   {5'd0, e.rot},   e.id);
                check("ack_lvl", {5'd0, acknowledged_level}, {5'd0, e.ack},  e.id);
                check("busy",    {7'd0, ack_busy},          {7'd0, e.busy},  e.id);
                $display("txn %0d isr=%h hi=%h rot=%0d ack=%0d busy=%0d", e.id,
                         in_service_register, highest_level_in_service,
                         priority_rotate, acknowledged_level, ack_busy);
            end
        end
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        int r;
        drive_defaults();
        m_rot = 7;
        reset_cycle();
        reset_cycle();

        ack_pair(8'h04, 1'b0, 1'b0);
        idle_cycle();
        eoi(1'b1, 1'b0, 3'd2);

        ack_pair(8'h10, 1'b1, 1'b1);
        idle_cycle();

        reset_cycle();
        inta(8'h00, 1'b0, 1'b0);
        idle_cycle();
        inta(8'h00, 1'b1, 1'b0);

        ack_pair(8'h02, 1'b0, 1'b0);
        ack_pair(8'h08, 1'b0, 1'b0);
        eoi(1'b0, 1'b0, 3'd0);
        eoi(1'b1, 1'b1, 3'd3);
        eoi(1'b0, 1'b1, 3'd0);

        set_priority(3'd2);
        ack_pair(8'h80, 1'b0, 1'b0);
        ack_pair(8'h02, 1'b0, 1'b0);
        idle_cycle();

        reset_cycle();
        for (int i = 0; i < 8; i++) ack_pair(8'h01 << i, 1'b0, 1'b0);
        inta(8'h20, 1'b0, 1'b0);
        reset_cycle();
        inta(8'h40, 1'b0, 1'b0);
        idle_cycle();

        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            drive_defaults();
            r = int'($urandom_range(0, 9));
            interrupt             = (r < 2) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
            interrupt_acknowledge = ($urandom_range(0, 2) == 0);
            auto_eoi_config       = $urandom_range(0, 1) != 0;
            auto_rotate_config    = $urandom_range(0, 1) != 0;
            eoi_valid             = ($urandom_range(0, 4) == 0);
            eoi_specific          = $urandom_range(0, 1) != 0;
            eoi_rotate            = $urandom_range(0, 1) != 0;
            eoi_level             = 3'($urandom_range(0, 7));
            set_priority_valid    = ($urandom_range(0, 9) == 0);
            set_priority_level    = 3'($urandom_range(0, 7));
            reset                 = ($urandom_range(0, 149) == 0);
            commit_cycle();
        end
        idle_cycle();
        driver_done = 1'b1;
    end

    initial begin
        int budget;
        wait (driver_done);
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_failures++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/kf8259_in_service_control.md
KF8259_IN_SERVICE_CONTROL -- requirements
Module: kf8259_in_service_control

Interface
REQ-001 Parameters: none; all widths fixed at 8 IR levels and 3-bit level codes.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 interrupt  input  8  one-hot winning request from the priority resolver; 0 means no request.
REQ-005 interrupt_acknowledge  input  1  single-cycle pulse per INTA strobe, already synchronized.
REQ-006 auto_eoi_config  input  1  1 = automatic EOI at end of the acknowledge sequence.
REQ-007 auto_rotate_config  input  1  1 = automatic EOI also rotates priority; honoured only per REQ-027.
REQ-008 eoi_valid  input  1  single-cycle OCW2 EOI command strobe.
REQ-009 eoi_specific  input  1  1 = clear eoi_level; 0 = clear the highest in-service level.
REQ-010 eoi_rotate  input  1  1 = the cleared level becomes the lowest priority.
REQ-011 eoi_level  input  3  target level for specific EOI.
REQ-012 set_priority_valid  input  1  single-cycle strobe; set_priority_level becomes the lowest priority.
REQ-013 set_priority_level  input  3  new lowest-priority level.
REQ-014 in_service_register  output  8  registered ISR.
REQ-015 highest_level_in_service  output  8  one-hot highest-priority set ISR bit under current rotation; 0 when ISR is 0.
REQ-016 priority_rotate  output  3  registered lowest-priority level.
REQ-017 acknowledged_level  output  3  level latched at first INTA, used for the vector.
REQ-018 ack_busy  output  1  high while the FSM is in WAIT_SECOND.

Function
REQ-019 The FSM SHALL have two states, IDLE and WAIT_SECOND.
REQ-020 IDLE plus interrupt_acknowledge SHALL take effect on the next edge:
- ISR |= interrupt.
- acknowledged_level = index of interrupt.
- Go to WAIT_SECOND.
REQ-021 If interrupt==0 at the first pulse (spurious request), the block SHALL latch acknowledged_level=7, leave the ISR unchanged, and still go to WAIT_SECOND.
REQ-022 WAIT_SECOND plus interrupt_acknowledge SHALL return to IDLE.
- If auto_eoi_config=1 and the request was not spurious, the same edge SHALL clear ISR[acknowledged_level].
REQ-023 eoi_valid SHALL clear exactly one ISR bit on the next edge:
- eoi_specific=1: ISR[eoi_level].
- eoi_specific=0: the bit in highest_level_in_service.
- Non-specific EOI with ISR=0: no clear and no rotate.
REQ-024 eoi_valid with eoi_rotate=1 SHALL set priority_rotate to the cleared level on the same edge.
REQ-025 Simultaneous events SHALL be resolved as follows:
- EOI and latch in the same cycle: the EOI clear is computed from the pre-edge ISR and the latch set is applied after it, so set wins on the same bit.
- set_priority_valid and any rotate in the same cycle: set_priority_valid wins.
REQ-026 highest_level_in_service SHALL be combinational from the registered ISR and priority_rotate: the first set bit scanning from level (priority_rotate+1) mod 8 upward with wrap-around; zero latency.

Configuration
REQ-027 The block SHALL honour the macro KF8259_AUTO_ROTATE_EN.
- Defined: an automatic EOI with auto_rotate_config=1 SHALL set priority_rotate to the cleared level.
- Undefined: auto_rotate_config SHALL be ignored and automatic EOI SHALL never change priority_rotate.

Reset
REQ-028 reset SHALL force the following on the next edge, overriding all strobes, including in the middle of an acknowledge sequence:
- FSM to IDLE.
- in_service_register=8'h00.
- priority_rotate=3'b111 (IR0 highest).
- acknowledged_level=3'b000.
- ack_busy=0.
REQ-029 As a consequence, highest_level_in_service SHALL be 8'h00 after reset.

Structure
REQ-030 The shared package kf8259_common_pkg SHALL hold:
- the FSM state typedef;
- the level-width constant;
- rotate-left/rotate-right helpers;
- the one-hot lowest-set-bit helper;
- the one-hot-to-index helper.
The priority resolver SHALL reuse the same helpers.
REQ-031 The block SHALL have no sub-module; the highest-level logic SHALL be built inline from the package helpers.

Verification
REQ-032 Normal acknowledge:
- Stimulus: after reset, interrupt=8'h04, then INTA, then INTA, with auto_eoi_config=0.
- Response: ISR=8'h04, acknowledged_level=2, ack_busy 1 then 0, ISR still 8'h04.
REQ-033 Automatic EOI:
- Stimulus: interrupt=8'h10, two INTA pulses, auto_eoi_config=1, auto_rotate_config=1.
- Response: ISR returns to 8'h00; priority_rotate=4 with the macro defined, 7 without it.
REQ-034 Spurious request:
- Stimulus: interrupt=8'h00, first INTA.
- Response: acknowledged_level=7, ISR unchanged, ack_busy=1.
REQ-035 EOI modes:
- Stimulus: ISR=8'h0A, non-specific EOI, then specific EOI with eoi_level=3 and eoi_rotate=1.
- Response: ISR becomes 8'h08, then 8'h00; priority_rotate=3.
REQ-036 Rotation:
- Stimulus: set_priority_level=2 applied, then ISR=8'h82.
- Response: highest_level_in_service=8'h80.
REQ-037 Reset in the middle of an acknowledge:
- Stimulus: reset asserted while in WAIT_SECOND with ISR=8'hFF.
- Response: all outputs at REQ-028 reset values on the next edge; a subsequent INTA is treated as a first pulse.
